// File: rtl/pong_game_engine_if.sv
// Pong engine bus: paddle/control inputs toward the engine, ball/score/status back out.
interface pong_game_engine_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               tick;
  logic               start;
  logic [9:0]         p1_y;
  logic [9:0]         p2_y;
  logic [10:0]        ball_x;
  logic [9:0]         ball_y;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               point_pulse;
  logic               game_over;
  logic               winner;
  logic [2:0]         state;

  modport master (
    output tick, start, p1_y, p2_y,
    input  ball_x, ball_y, score1, score2, point_pulse, game_over, winner, state
  );

  modport slave (
    input  tick, start, p1_y, p2_y,
    output ball_x, ball_y, score1, score2, point_pulse, game_over, winner, state
  );
endinterface

// File: rtl/pong_game_engine.sv
// Pong game core: ball motion, wall/paddle bounce, scoring, serve hold and win detection.
// Advances once per frame tick. Optional build macro PONG_BALL_SPEEDUP_EN makes each
// paddle hit raise the ball step by one, up to MAX_SPEED.
module pong_game_engine #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_SIZE   = 10,
  parameter int unsigned PAD_W       = 10,
  parameter int unsigned PAD_H       = 50,
  parameter int unsigned P1_X        = 20,
  parameter int unsigned P2_X        = 620,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned MAX_SPEED   = 6,
  parameter int unsigned SCORE_W     = 4,
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_TICKS = 60
) (
  input logic               board_clk,
  input logic               reset,
  pong_game_engine_if.slave bus
);

  localparam int unsigned XW  = 11;
  localparam int unsigned YW  = 10;
  localparam int unsigned XW1 = XW + 1;
  localparam int unsigned YW1 = YW + 1;
  localparam int unsigned CW  = $clog2(SERVE_TICKS + 1);

  localparam logic [XW-1:0]      X_MAX     = XW'(SCREEN_W - BALL_SIZE);
  localparam logic [YW-1:0]      Y_MAX     = YW'(SCREEN_H - BALL_SIZE);
  localparam logic [XW-1:0]      X_CTR     = XW'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [YW-1:0]      Y_CTR     = YW'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [YW-1:0]      PAD_Y_MAX = YW'(SCREEN_H - PAD_H);
  localparam logic [XW-1:0]      P1_FACE   = XW'(P1_X + PAD_W);
  localparam logic [XW-1:0]      P2_FACE   = XW'(P2_X - BALL_SIZE);
  localparam logic [YW-1:0]      SPD_INIT  = YW'(SPEED);
  localparam logic [SCORE_W-1:0] WIN_M1    = SCORE_W'(WIN_SCORE - 1);
  localparam logic [CW-1:0]      SERVE_END = CW'(SERVE_TICKS - 1);

  // Scores must not wrap before reaching the winning value.
  if (WIN_SCORE >= (1 << SCORE_W) || MAX_SPEED < SPEED) begin : g_param_chk
    $error("pong_game_engine: WIN_SCORE must fit in SCORE_W and MAX_SPEED >= SPEED");
  end

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    MOVE      = 3'd2,
    CHECK     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t             state_q;
  logic [XW-1:0]      ball_x_q;
  logic [YW-1:0]      ball_y_q;
  logic [SCORE_W-1:0] score1_q, score2_q;
  logic               point_pulse_q, game_over_q, winner_q;
  logic               dx_q, dy_q;
  logic [YW-1:0]      speed_q;
  logic [CW-1:0]      serve_cnt_q;
  logic [YW-1:0]      p1_lat_q, p2_lat_q;
  logic               start_q;

  logic [XW1-1:0] bx_right_c, x_up_c;
  logic [YW1-1:0] by_bot_c, y_up_c, p1_bot_c, p2_bot_c;
  logic [XW-1:0]  x_next_c;
  logic [YW-1:0]  y_next_c, spd_hit_c;
  logic           p1_hit_c, p2_hit_c;

  function automatic logic [YW-1:0] pad_clamp(input logic [YW-1:0] p);
    return (p > PAD_Y_MAX) ? PAD_Y_MAX : p;
  endfunction

  // Saturating step, collision tests and hit speed for the current ball state.
  always_comb begin
    bx_right_c = XW1'(ball_x_q) + XW1'(BALL_SIZE);
    by_bot_c   = YW1'(ball_y_q) + YW1'(BALL_SIZE);
    p1_bot_c   = YW1'(p1_lat_q) + YW1'(PAD_H);
    p2_bot_c   = YW1'(p2_lat_q) + YW1'(PAD_H);
    x_up_c     = XW1'(ball_x_q) + XW1'(speed_q);
    y_up_c     = YW1'(ball_y_q) + YW1'(speed_q);

    if (dx_q) x_next_c = (x_up_c > XW1'(X_MAX)) ? X_MAX : x_up_c[XW-1:0];
    else      x_next_c = (ball_x_q < XW'(speed_q)) ? '0 : ball_x_q - XW'(speed_q);
    if (dy_q) y_next_c = (y_up_c > YW1'(Y_MAX)) ? Y_MAX : y_up_c[YW-1:0];
    else      y_next_c = (ball_y_q < speed_q) ? '0 : ball_y_q - speed_q;

    p1_hit_c = !dx_q && (ball_x_q <= P1_FACE) && (bx_right_c > XW1'(P1_X)) &&
               (by_bot_c > YW1'(p1_lat_q)) && (YW1'(ball_y_q) < p1_bot_c);
    p2_hit_c = dx_q && (bx_right_c >= XW1'(P2_X)) && (ball_x_q < XW'(P2_X + PAD_W)) &&
               (by_bot_c > YW1'(p2_lat_q)) && (YW1'(ball_y_q) < p2_bot_c);

`ifdef PONG_BALL_SPEEDUP_EN
    spd_hit_c = (speed_q >= YW'(MAX_SPEED)) ? YW'(MAX_SPEED) : speed_q + YW'(1);
`else
    spd_hit_c = speed_q;
`endif
  end

  // Game FSM with all outputs registered.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ball_x_q      <= X_CTR;
      ball_y_q      <= Y_CTR;
      score1_q      <= '0;
      score2_q      <= '0;
      point_pulse_q <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
      dx_q          <= 1'b1;
      dy_q          <= 1'b1;
      speed_q       <= SPD_INIT;
      serve_cnt_q   <= '0;
      p1_lat_q      <= '0;
      p2_lat_q      <= '0;
      start_q       <= 1'b0;
    end else begin
      point_pulse_q <= 1'b0;
      start_q       <= bus.start;
      unique case (state_q)
        IDLE: begin
          ball_x_q <= X_CTR;
          ball_y_q <= Y_CTR;
          score1_q <= '0;
          score2_q <= '0;
          dx_q     <= 1'b1;
          if (bus.start) begin
            state_q     <= SERVE;
            serve_cnt_q <= '0;
          end
        end
        SERVE: begin
          ball_x_q <= X_CTR;
          ball_y_q <= Y_CTR;
          if (bus.tick) begin
            if (serve_cnt_q == SERVE_END) begin
              serve_cnt_q <= '0;
              state_q     <= MOVE;
            end else begin
              serve_cnt_q <= serve_cnt_q + CW'(1);
            end
          end
        end
        MOVE: begin
          if (bus.tick) begin
            ball_x_q <= x_next_c;
            ball_y_q <= y_next_c;
            p1_lat_q <= pad_clamp(bus.p1_y);
            p2_lat_q <= pad_clamp(bus.p2_y);
            state_q  <= CHECK;
          end
        end
        CHECK: begin
          state_q <= MOVE;
          if (ball_y_q == '0)        dy_q <= 1'b1;
          else if (ball_y_q == Y_MAX) dy_q <= 1'b0;
          if (p1_hit_c) begin
            dx_q     <= 1'b1;
            ball_x_q <= P1_FACE;
            speed_q  <= spd_hit_c;
          end else if (p2_hit_c) begin
            dx_q     <= 1'b0;
            ball_x_q <= P2_FACE;
            speed_q  <= spd_hit_c;
          end else if (ball_x_q == '0 || ball_x_q == X_MAX) begin
            point_pulse_q <= 1'b1;
            ball_x_q      <= X_CTR;
            ball_y_q      <= Y_CTR;
            speed_q       <= SPD_INIT;
            serve_cnt_q   <= '0;
            state_q       <= SERVE;
            if (ball_x_q == '0) begin
              score2_q <= score2_q + SCORE_W'(1);
              dx_q     <= 1'b0;
              if (score2_q == WIN_M1) begin
                state_q     <= GAME_OVER;
                game_over_q <= 1'b1;
                winner_q    <= 1'b1;
              end
            end else begin
              score1_q <= score1_q + SCORE_W'(1);
              dx_q     <= 1'b1;
              if (score1_q == WIN_M1) begin
                state_q     <= GAME_OVER;
                game_over_q <= 1'b1;
                winner_q    <= 1'b0;
              end
            end
          end
        end
        GAME_OVER: begin
          if (bus.start && !start_q) begin
            state_q     <= IDLE;
            game_over_q <= 1'b0;
            score1_q    <= '0;
            score2_q    <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Drive the bus from the registered state.
  assign bus.ball_x      = ball_x_q;
  assign bus.ball_y      = ball_y_q;
  assign bus.score1      = score1_q;
  assign bus.score2      = score2_q;
  assign bus.point_pulse = point_pulse_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;
  assign bus.state       = state_q;

endmodule
